dequantization: RTL and testbench

Streaming inverse of the OFM quantizer. Accepts 8-bit quantized activations and expands each into the packed exponent/mantissa word used by the accumulation datapath: {exponent[7:0], mantissa[W-9:0]}. Any word it produces, passed back through the quantizer (mantissa >> (exponent − 127)), returns the original 8-bit value exactly. It sits between the activation buffer read port and the PE-array operand feed, with a two-stage valid/ready pipeline.

---
 rtl/dequantization_if.sv | 25 ++
 rtl/dequantization.sv | 92 +++++++++
 tb/tb_dequantization.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dequantization_if.sv
// Stream bundle for the dequantizer: quantized activations in, {exponent, mantissa} words out.
// The slave modport is the dequantizer; the master modport is whatever feeds and drains it.
interface dequantization_if #(
   parameter int input_width  = 8,
   parameter int output_width = 20
);
   logic                    in_valid;
   logic                    in_ready;
   logic [input_width-1:0]  ifm_input;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic [output_width-1:0] ofm_output;
   logic                    out_last;

   modport slave (
      input  in_valid, ifm_input, in_last, out_ready,
      output in_ready, out_valid, ofm_output, out_last
   );

   modport master (
      output in_valid, ifm_input, in_last, out_ready,
      input  in_ready, out_valid, ofm_output, out_last
   );
endinterface

// File: rtl/dequantization.sv
// Expands 8-bit quantized activations into normalized {exponent, mantissa} words; 2-cycle latency.
// Stalled outputs hold stable; in_ready drops only when both stages are full and out_ready is low.
module dequantization #(
   parameter int input_width  = 8,
   parameter int output_width = 20,
   parameter int exp_bias     = 127
) (
   input  logic                clk,
   input  logic                rst,
   dequantization_if.slave     bus,
   output logic [15:0]         frame_count,
   output logic                busy
);
   localparam int M  = output_width - 8;
   localparam int PW = (input_width > 1) ? $clog2(input_width) : 1;

   typedef struct packed {
      logic [7:0]   exponent;
      logic [M-1:0] mantissa;
   } word_t;

   logic                   advance;
   logic                   s1_valid;
   logic                   s1_last;
   logic                   s1_zero;
   logic [input_width-1:0] s1_q;
   logic [PW-1:0]          s1_p;
   logic [PW-1:0]          lead_idx;
   logic [7:0]             shift;
   word_t                  enc;

   assign advance      = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = !s1_valid || advance;
   assign busy         = s1_valid || bus.out_valid;

   // Highest set bit wins because later iterations overwrite earlier ones.
   always_comb begin
      lead_idx = '0;
      for (int i = 0; i < input_width; i++) begin
         if (bus.ifm_input[i]) lead_idx = PW'(i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
         s1_p     <= '0;
         s1_zero  <= 1'b1;
         s1_last  <= 1'b0;
      end else if (bus.in_ready) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_q    <= bus.ifm_input;
            s1_p    <= lead_idx;
            s1_zero <= (bus.ifm_input == '0);
            s1_last <= bus.in_last;
         end
      end
   end

   // Shift the leading one up to the mantissa MSB; the exponent absorbs the shift.
   always_comb begin
      shift        = 8'(M - 1 - int'(s1_p));
      enc.mantissa = M'(s1_q) << shift;
      enc.exponent = 8'(exp_bias) + shift;
      if (s1_zero) begin
         enc.mantissa = '0;
         enc.exponent = 8'(exp_bias);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid  <= 1'b0;
         bus.ofm_output <= '0;
         bus.out_last   <= 1'b0;
      end else if (advance) begin
         bus.out_valid <= s1_valid;
         bus.out_last  <= s1_valid && s1_last;
         if (s1_valid) bus.ofm_output <= enc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_count <= '0;
      end else if (bus.out_valid && bus.out_ready && bus.out_last) begin
         frame_count <= frame_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_dequantization.sv
// Directed bench for the dequantizer: encoding vectors, round trip, backpressure, framing, reset, wrap.
module tb_dequantization;
   localparam int IW = 8;
   localparam int OW = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] frame_count;
   logic        busy;
   int          checks = 0;
   int          fails  = 0;

   dequantization_if #(.input_width(IW), .output_width(OW)) bus ();

   dequantization #(.input_width(IW), .output_width(OW), .exp_bias(127)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .frame_count (frame_count),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Normalizes by shifting until the mantissa MSB is set, counting the shifts.
   function automatic logic [19:0] model(input logic [7:0] q);
      logic [11:0] m;
      int          s;
      if (q == 8'd0) return {8'd127, 12'd0};
      m = {4'b0, q};
      s = 0;
      while (!m[11]) begin
         m = m << 1;
         s++;
      end
      return {8'(127 + s), m};
   endfunction

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.ifm_input = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      rst           = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
      checks++;
      if (bus.ofm_output !== 20'h0) begin fails++; $display("FAIL reset_ofm_output: got %h, required 00000", bus.ofm_output); end
      checks++;
      if (bus.out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %b, required 0", bus.out_last); end
      checks++;
      if (frame_count !== 16'h0) begin fails++; $display("FAIL reset_frame_count: got %h, required 0000", frame_count); end
      checks++;
      if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
   endtask

   task automatic test_basic();
      logic [7:0]  qv [4];
      logic [19:0] ev [4];
      qv = '{8'h00, 8'h01, 8'h80, 8'hFF};
      ev = '{20'h7F000, 20'h8A800, 20'h83800, 20'h83FF0};
      bus.out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++;
         if (c >= 2 && c < 6) begin
            if (bus.out_valid !== 1'b1 || bus.ofm_output !== ev[c-2]) begin
               fails++;
               $display("FAIL basic_word%0d: valid=%b word=%h, required valid=1 word=%h", c - 2, bus.out_valid, bus.ofm_output, ev[c-2]);
            end
         end else if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle_c%0d: valid=%b, required 0", c, bus.out_valid);
         end
         bus.in_valid = (c < 4);
         if (c < 4) bus.ifm_input = qv[c];
      end
   endtask

   task automatic test_roundtrip();
      logic [7:0]  e;
      logic [11:0] m;
      int          k;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 260; c++) begin
         @(negedge clk);
         if (c >= 2 && c < 258) begin
            k = c - 2;
            e = bus.ofm_output[19:12];
            m = bus.ofm_output[11:0];
            checks++;
            if (bus.out_valid !== 1'b1) begin
               fails++;
               $display("FAIL rt_valid q=%0d: valid=%b, required 1", k, bus.out_valid);
            end
            checks++;
            if ((m >> (e - 8'd127)) !== 12'(k)) begin
               fails++;
               $display("FAIL rt_inverse q=%0d: word=%h decodes to %0d, required %0d", k, bus.ofm_output, m >> (e - 8'd127), k);
            end
            if (k != 0) begin
               checks++;
               if (m[11] !== 1'b1) begin fails++; $display("FAIL rt_msb q=%0d: mantissa=%h, required MSB 1", k, m); end
            end
            checks++;
            if (bus.ofm_output !== model(8'(k))) begin
               fails++;
               $display("FAIL rt_word q=%0d: got %h, required %h", k, bus.ofm_output, model(8'(k)));
            end
         end
         bus.in_valid = (c < 256);
         bus.ifm_input = 8'(c);
      end
   endtask

   task automatic test_backpressure();
      logic [0:39] pat;
      logic [7:0]  bq [10];
      logic [19:0] held;
      logic        ordy, stalled, out_hs, in_hs, exp_rdy;
      int          tx, rx, occ;
      pat = 40'b00000_10110_10011_01110_11111_11111_11111_11111;
      for (int k = 0; k < 10; k++) bq[k] = 8'(k * 29 + 3);
      tx = 0; rx = 0; occ = 0; stalled = 1'b0; held = '0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         ordy = (c < 40) ? pat[c] : 1'b1;
         bus.out_ready = ordy;
         #1;
         if (stalled) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.ofm_output !== held) begin
               fails++;
               $display("FAIL bp_stable c%0d: valid=%b word=%h, required valid=1 word=%h", c, bus.out_valid, bus.ofm_output, held);
            end
         end
         exp_rdy = (occ < 2) || ordy;
         checks++;
         if (bus.in_ready !== exp_rdy) begin
            fails++;
            $display("FAIL bp_in_ready c%0d: got %b, required %b (occupancy %0d)", c, bus.in_ready, exp_rdy, occ);
         end
         out_hs = bus.out_valid && ordy;
         if (out_hs) begin
            checks++;
            if (bus.ofm_output !== model(bq[rx])) begin
               fails++;
               $display("FAIL bp_order #%0d: got %h, required %h", rx, bus.ofm_output, model(bq[rx]));
            end
            rx++;
         end
         stalled = bus.out_valid && !ordy;
         held    = bus.ofm_output;
         bus.in_valid = (tx < 10);
         if (tx < 10) bus.ifm_input = bq[tx];
         #1;
         in_hs = bus.in_valid && bus.in_ready;
         if (in_hs) tx++;
         occ = occ + int'(in_hs) - int'(out_hs);
         if (rx == 10) break;
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (rx != 10 || tx != 10) begin
         fails++;
         $display("FAIL bp_count: sent %0d received %0d, required 10 and 10", tx, rx);
      end
   endtask

   task automatic test_framing();
      logic [0:11] lm;
      int          nf;
      lm = 12'b1000_1000_0001;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 17; c++) begin
         @(negedge clk);
         if (c >= 2 && c < 14) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.ofm_output !== model(8'((c - 2) * 37 + 5)) || bus.out_last !== lm[c-2]) begin
               fails++;
               $display("FAIL frame_word%0d: valid=%b word=%h last=%b, required valid=1 word=%h last=%b",
                        c - 2, bus.out_valid, bus.ofm_output, bus.out_last, model(8'((c - 2) * 37 + 5)), lm[c-2]);
            end
         end
         nf = 0;
         for (int k = 0; k < 12; k++) if (lm[k] && k + 3 <= c) nf++;
         checks++;
         if (frame_count !== 16'(nf)) begin
            fails++;
            $display("FAIL frame_count c%0d: got %0d, required %0d", c, frame_count, nf);
         end
         bus.in_valid = (c < 12);
         bus.in_last  = (c < 12) ? lm[c] : 1'b0;
         bus.ifm_input = 8'(c * 37 + 5);
      end
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         bus.in_valid  = 1'b1;
         bus.ifm_input = 8'(c + 9);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_full: valid=%b busy=%b in_ready=%b, required 1 1 0", bus.out_valid, busy, bus.in_ready);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0 || frame_count !== 16'h0) begin
         fails++;
         $display("FAIL rstmid_async: valid=%b busy=%b count=%0d, required 0 0 0", bus.out_valid, busy, frame_count);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_stale c%0d: valid=%b busy=%b, required 0 0", c, bus.out_valid, busy);
         end
      end
   endtask

   task automatic test_wrap();
      bus.out_ready = 1'b1;
      bus.in_last   = 1'b1;
      bus.ifm_input = 8'h42;
      for (int c = 0; c < 65535; c++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (frame_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %h, required FFFF", frame_count); end
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (frame_count !== 16'hFFFF || bus.out_last !== 1'b1) begin
         fails++;
         $display("FAIL wrap_before: count=%h last=%b, required FFFF 1", frame_count, bus.out_last);
      end
      @(negedge clk);
      checks++;
      if (frame_count !== 16'h0000) begin fails++; $display("FAIL wrap_after: got %h, required 0000", frame_count); end
      bus.in_last = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_roundtrip();
      test_backpressure();
      test_framing();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
